// File: rtl/conv_ctrl_pkg.sv
// Shared types and elaboration-time helpers for the fast shift-register convolution controller.
package conv_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } ctrl_state_e;

  // Output feature-map extent along one axis (RESULT_W / RESULT_H).
  function automatic int unsigned result_dim(input int unsigned img, input int unsigned filt,
                                             input int unsigned stride);
    return (img - filt) / stride + 1;
  endfunction

  // Last image column touched by a row of windows (LAST_COL).
  function automatic int unsigned last_col(input int unsigned result_w, input int unsigned filt,
                                           input int unsigned stride_w);
    return (result_w - 1) * stride_w + filt - 1;
  endfunction

  // Address width that never collapses to zero bits.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

  // True when bank's row crosses one extra FILTER_L boundary as the window top
  // advances by the stride remainder sh_r (offset of bank from top < sh_r).
  function automatic logic bank_wraps(input int unsigned bank, input int unsigned rot,
                                      input int unsigned filt, input int unsigned sh_r);
    int unsigned off;
    off = (bank >= rot) ? bank - rot : bank + filt - rot;
    return off < sh_r;
  endfunction

endpackage

// File: rtl/conv_bram_sr_fast_ctrl_if.sv
// Image-BRAM read side and datapath control side of the convolution controller.
interface conv_bram_sr_fast_ctrl_if #(
  parameter int unsigned IMG_W    = 16,
  parameter int unsigned IMG_H    = 16,
  parameter int unsigned FILTER_L = 3,
  parameter int unsigned STRIDE_W = 1,
  parameter int unsigned STRIDE_H = 1
);

  localparam int unsigned RESULT_W = conv_ctrl_pkg::result_dim(IMG_W, FILTER_L, STRIDE_W);
  localparam int unsigned RESULT_H = conv_ctrl_pkg::result_dim(IMG_H, FILTER_L, STRIDE_H);
  localparam int unsigned BANK_ADDR_WIDTH =
    conv_ctrl_pkg::clog2_min1(((IMG_H + FILTER_L - 1) / FILTER_L) * IMG_W);
  localparam int unsigned FILTER_L_ADDR_WIDTH   = conv_ctrl_pkg::clog2_min1(FILTER_L);
  localparam int unsigned RESULT_RAM_ADDR_WIDTH = conv_ctrl_pkg::clog2_min1(RESULT_W * RESULT_H);

  logic                                img_rden;
  logic [FILTER_L*BANK_ADDR_WIDTH-1:0] img_rdaddr;
  logic                                dpath_wren;
  logic [FILTER_L_ADDR_WIDTH-1:0]      dpath_rotation_offset;
  logic [RESULT_RAM_ADDR_WIDTH-1:0]    dpath_result_wraddr;
  logic                                last_val;

  modport master (
    output img_rden, img_rdaddr, dpath_wren, dpath_rotation_offset, dpath_result_wraddr,
    input  last_val
  );

  modport slave (
    input  img_rden, img_rdaddr, dpath_wren, dpath_rotation_offset, dpath_result_wraddr,
    output last_val
  );

endinterface

// File: rtl/conv_ctrl_delay_line.sv
// WIDTH x DEPTH register pipeline with synchronous clear; aligns tagged controls to BRAM latency.
module conv_ctrl_delay_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] pipe [DEPTH];

  // Shift the tag one stage per cycle; reset flushes every stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= d;
      for (int i = 1; i < int'(DEPTH); i++) pipe[i] <= pipe[i-1];
    end
  end

  assign q = pipe[DEPTH-1];

endmodule

// File: rtl/conv_bram_sr_fast_ctrl.sv
// Row-by-row issue controller for the fast shift-register convolution datapath.
// Optional cycle counter output perf_cycles is built when CONV_CTRL_PERF_CNT_EN is defined.
module conv_bram_sr_fast_ctrl
  import conv_ctrl_pkg::*;
#(
  parameter int unsigned IMG_W      = 16,
  parameter int unsigned IMG_H      = 16,
  parameter int unsigned FILTER_L   = 3,
  parameter int unsigned STRIDE_W   = 1,
  parameter int unsigned STRIDE_H   = 1,
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy,
  output logic done,
  conv_bram_sr_fast_ctrl_if.master dp
`ifdef CONV_CTRL_PERF_CNT_EN
  ,
  output logic [31:0] perf_cycles
`endif
);

  localparam int unsigned RESULT_W = result_dim(IMG_W, FILTER_L, STRIDE_W);
  localparam int unsigned RESULT_H = result_dim(IMG_H, FILTER_L, STRIDE_H);
  localparam int unsigned LAST_COL = last_col(RESULT_W, FILTER_L, STRIDE_W);
  localparam int unsigned BAW      = clog2_min1(((IMG_H + FILTER_L - 1) / FILTER_L) * IMG_W);
  localparam int unsigned FAW      = clog2_min1(FILTER_L);
  localparam int unsigned RAW      = clog2_min1(RESULT_W * RESULT_H);
  localparam int unsigned COL_W    = clog2_min1(LAST_COL + 1);
  localparam int unsigned OH_W     = clog2_min1(RESULT_H);
  localparam int unsigned ROT_W    = FAW + 1;
  localparam int unsigned SH_Q     = STRIDE_H / FILTER_L;
  localparam int unsigned SH_R     = STRIDE_H % FILTER_L;
  localparam int unsigned STEP     = SH_Q * IMG_W;
  localparam int unsigned TAG_W    = 1 + FAW + RAW;

  ctrl_state_e state, state_n;

  logic             issue_c, row_end_c, last_issue_c, start_acc_c;
  logic [COL_W-1:0] col, win_end;
  logic [OH_W-1:0]  oh;
  logic [FAW-1:0]   rot, rot_n;
  logic [ROT_W-1:0] rot_sum;
  logic [RAW-1:0]   wraddr;
  logic [BAW-1:0]   base   [FILTER_L];
  logic [BAW-1:0]   base_n [FILTER_L];
  logic [BAW-1:0]   addr   [FILTER_L];
  logic             rden_q, busy_q, done_q;
  logic [TAG_W-1:0] tag_d, tag_q;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state logic and per-cycle issue strobes.
  always_comb begin
    state_n      = state;
    issue_c      = 1'b0;
    row_end_c    = 1'b0;
    last_issue_c = 1'b0;
    start_acc_c  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n     = RUN;
          start_acc_c = 1'b1;
        end
      end
      RUN: begin
        issue_c = 1'b1;
        if (col == COL_W'(LAST_COL)) begin
          row_end_c = 1'b1;
          if (oh == OH_W'(RESULT_H - 1)) begin
            last_issue_c = 1'b1;
            state_n      = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (dp.last_val) state_n = DONE;
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Window-top advance: rotation modulo FILTER_L and per-bank row bases by compare-and-add.
  always_comb begin
    rot_sum = ROT_W'(rot) + ROT_W'(SH_R);
    rot_n   = (rot_sum >= ROT_W'(FILTER_L)) ? FAW'(rot_sum - ROT_W'(FILTER_L)) : FAW'(rot_sum);
    for (int b = 0; b < int'(FILTER_L); b++) begin
      base_n[b] = base[b] + BAW'(STEP)
                + (bank_wraps(b, 32'(rot), FILTER_L, SH_R) ? BAW'(IMG_W) : BAW'(0));
    end
  end

  // Issue counters; everything returns to zero at reset, on accepted start and after the last issue.
  always_ff @(posedge clk) begin
    if (reset || start_acc_c || last_issue_c) begin
      col     <= '0;
      win_end <= COL_W'(FILTER_L - 1);
      oh      <= '0;
      rot     <= '0;
      wraddr  <= '0;
      for (int b = 0; b < int'(FILTER_L); b++) begin
        base[b] <= '0;
        addr[b] <= '0;
      end
    end else if (issue_c) begin
      if (col == win_end) begin
        wraddr  <= wraddr + RAW'(1);
        win_end <= win_end + COL_W'(STRIDE_W);
      end
      if (row_end_c) begin
        col     <= '0;
        win_end <= COL_W'(FILTER_L - 1);
        oh      <= oh + OH_W'(1);
        rot     <= rot_n;
        for (int b = 0; b < int'(FILTER_L); b++) begin
          base[b] <= base_n[b];
          addr[b] <= base_n[b];
        end
      end else begin
        col <= col + COL_W'(1);
        for (int b = 0; b < int'(FILTER_L); b++) addr[b] <= addr[b] + BAW'(1);
      end
    end
  end

  // Registered status and read enable, decoded from the upcoming state.
  always_ff @(posedge clk) begin
    if (reset) begin
      rden_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rden_q <= (state_n == RUN);
      busy_q <= (state_n == RUN) || (state_n == DRAIN);
      done_q <= (state_n == DONE);
    end
  end

  // Tagged controls ride the delay line so they meet the matching BRAM read data.
  always_comb begin
    tag_d = {issue_c, issue_c ? rot : FAW'(0), issue_c ? wraddr : RAW'(0)};
  end

  conv_ctrl_delay_line #(
    .WIDTH (TAG_W),
    .DEPTH (RD_LATENCY)
  ) u_tag_dly (
    .clk   (clk),
    .reset (reset),
    .d     (tag_d),
    .q     (tag_q)
  );

  assign busy                     = busy_q;
  assign done                     = done_q;
  assign dp.img_rden              = rden_q;
  assign dp.dpath_wren            = tag_q[TAG_W-1];
  assign dp.dpath_rotation_offset = tag_q[RAW +: FAW];
  assign dp.dpath_result_wraddr   = tag_q[RAW-1:0];

  for (genvar gb = 0; gb < int'(FILTER_L); gb++) begin : g_addr
    assign dp.img_rdaddr[gb*BAW +: BAW] = addr[gb];
  end

`ifdef CONV_CTRL_PERF_CNT_EN
  logic [31:0] perf_q;

  // Saturating count of busy cycles, cleared by the accepted start.
  always_ff @(posedge clk) begin
    if (reset || start_acc_c)           perf_q <= '0;
    else if (busy_q && (perf_q != '1))  perf_q <= perf_q + 32'd1;
  end

  assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_conv_bram_sr_fast_ctrl.sv
// Directed bench: default-stride instance A and stride-2 instance B run side by side.
module tb_conv_bram_sr_fast_ctrl;

  localparam int unsigned NC  = 240;
  localparam int unsigned BAW = 7;

  logic clk = 1'b0;
  logic reset, start_a, start_b, busy_a, done_a, busy_b, done_b;
  int   n_checks = 0;
  int   n_fails  = 0;
`ifdef CONV_CTRL_PERF_CNT_EN
  logic [31:0] perf_a, perf_b;
`endif

  always #5 clk = ~clk;

  conv_bram_sr_fast_ctrl_if if_a ();
  conv_bram_sr_fast_ctrl_if #(.STRIDE_W(2), .STRIDE_H(2)) if_b ();

  conv_bram_sr_fast_ctrl dut_a (
    .clk   (clk),
    .reset (reset),
    .start (start_a),
    .busy  (busy_a),
    .done  (done_a),
    .dp    (if_a)
`ifdef CONV_CTRL_PERF_CNT_EN
    ,
    .perf_cycles (perf_a)
`endif
  );

  conv_bram_sr_fast_ctrl #(.STRIDE_W(2), .STRIDE_H(2)) dut_b (
    .clk   (clk),
    .reset (reset),
    .start (start_b),
    .busy  (busy_b),
    .done  (done_b),
    .dp    (if_b)
`ifdef CONV_CTRL_PERF_CNT_EN
    ,
    .perf_cycles (perf_b)
`endif
  );

  logic             rd_a [NC];
  logic [3*BAW-1:0] ad_a [NC];
  logic             wr_a [NC];
  logic [1:0]       ro_a [NC];
  logic [7:0]       wa_a [NC];
  logic             bz_a [NC];
  logic             dn_a [NC];
  logic             rd_b [NC];
  logic [3*BAW-1:0] ad_b [NC];
  logic             wr_b [NC];
  logic [1:0]       ro_b [NC];
  logic [5:0]       wa_b [NC];
  logic             bz_b [NC];
  logic             dn_b [NC];

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Start both instances and record NC cycles; stray start/last_val pulses land mid-RUN.
  task automatic run_layer();
    start_a = 1'b1;
    start_b = 1'b1;
    for (int c = 0; c < int'(NC); c++) begin
      @(negedge clk);
      rd_a[c] = if_a.img_rden;   ad_a[c] = if_a.img_rdaddr;
      wr_a[c] = if_a.dpath_wren; ro_a[c] = if_a.dpath_rotation_offset;
      wa_a[c] = if_a.dpath_result_wraddr; bz_a[c] = busy_a; dn_a[c] = done_a;
      rd_b[c] = if_b.img_rden;   ad_b[c] = if_b.img_rdaddr;
      wr_b[c] = if_b.dpath_wren; ro_b[c] = if_b.dpath_rotation_offset;
      wa_b[c] = if_b.dpath_result_wraddr; bz_b[c] = busy_b; dn_b[c] = done_b;
      start_a = (c == 100);
      start_b = (c == 60);
      if_a.last_val = (c == 50) || (c == 228);
      if_b.last_val = (c == 108);
    end
  endtask

  task automatic check_layer(input string run);
    int frd_a = -1, fwr_a = -1, nrd_a = 0, nwr_a = 0, nbz_a = 0, ndn_a = 0, dat_a = -1;
    int frd_b = -1, fwr_b = -1, nrd_b = 0, nwr_b = 0, nbz_b = 0, ndn_b = 0, dat_b = -1;
    for (int c = 0; c < int'(NC); c++) begin
      if (rd_a[c]) begin nrd_a++; if (frd_a < 0) frd_a = c; end
      if (wr_a[c]) begin nwr_a++; if (fwr_a < 0) fwr_a = c; end
      if (bz_a[c]) nbz_a++;
      if (dn_a[c]) begin ndn_a++; dat_a = c; end
      if (rd_b[c]) begin nrd_b++; if (frd_b < 0) frd_b = c; end
      if (wr_b[c]) begin nwr_b++; if (fwr_b < 0) fwr_b = c; end
      if (bz_b[c]) nbz_b++;
      if (dn_b[c]) begin ndn_b++; dat_b = c; end
    end
    check({run, "_a_first_rden"}, frd_a, 0);
    check({run, "_a_wren_latency"}, fwr_a - frd_a, 2);
    check({run, "_a_issue_cycles"}, nrd_a, 224);
    check({run, "_a_wren_count"}, nwr_a, 224);
    check({run, "_a_busy_cycles"}, nbz_a, 229);
    check({run, "_a_done_pulses"}, ndn_a, 1);
    check({run, "_a_done_cycle"}, dat_a, 229);
    check({run, "_a_oh1c5_bank0"}, ad_a[21][BAW-1:0], 21);
    check({run, "_a_oh1c5_bank1"}, ad_a[21][2*BAW-1:BAW], 5);
    check({run, "_a_oh1c5_bank2"}, ad_a[21][3*BAW-1:2*BAW], 5);
    check({run, "_a_oh1c5_rot"}, ro_a[23], 1);
    check({run, "_a_last_bank0"}, ad_a[223][BAW-1:0], 95);
    check({run, "_a_last_bank1"}, ad_a[223][2*BAW-1:BAW], 79);
    check({run, "_a_last_bank2"}, ad_a[223][3*BAW-1:2*BAW], 79);
    for (int j = 0; j < 16; j++)
      check($sformatf("%s_a_row0_wraddr%0d", run, j), wa_a[2+j], (j < 3) ? 0 : j - 2);
    check({run, "_a_last_wraddr"}, wa_a[225], 195);
    check({run, "_b_first_rden"}, frd_b, 0);
    check({run, "_b_wren_latency"}, fwr_b - frd_b, 2);
    check({run, "_b_issue_cycles"}, nrd_b, 105);
    check({run, "_b_wren_count"}, nwr_b, 105);
    check({run, "_b_busy_cycles"}, nbz_b, 109);
    check({run, "_b_done_pulses"}, ndn_b, 1);
    check({run, "_b_done_cycle"}, dat_b, 109);
    check({run, "_b_oh1c0_bank0"}, ad_b[15][BAW-1:0], 16);
    check({run, "_b_oh1c0_bank1"}, ad_b[15][2*BAW-1:BAW], 16);
    check({run, "_b_oh1c0_bank2"}, ad_b[15][3*BAW-1:2*BAW], 0);
    check({run, "_b_oh1_rot"}, ro_b[17], 2);
    check({run, "_b_oh2_rot"}, ro_b[32], 1);
    check({run, "_b_last_bank0"}, ad_b[104][BAW-1:0], 78);
    check({run, "_b_last_bank1"}, ad_b[104][2*BAW-1:BAW], 78);
    check({run, "_b_last_bank2"}, ad_b[104][3*BAW-1:2*BAW], 78);
    for (int j = 0; j < 15; j++)
      check($sformatf("%s_b_row0_wraddr%0d", run, j), wa_b[2+j], (j < 3) ? 0 : (j - 1) / 2);
    check({run, "_b_last_wraddr"}, wa_b[106], 48);
`ifdef CONV_CTRL_PERF_CNT_EN
    check({run, "_a_perf_cycles"}, perf_a, 229);
    check({run, "_b_perf_cycles"}, perf_b, 109);
`endif
  endtask

  task automatic check_idle_a(input string run);
    check({run, "_busy"}, busy_a, 0);
    check({run, "_done"}, done_a, 0);
    check({run, "_rden"}, if_a.img_rden, 0);
    check({run, "_rdaddr"}, if_a.img_rdaddr, 0);
    check({run, "_wren"}, if_a.dpath_wren, 0);
    check({run, "_rot"}, if_a.dpath_rotation_offset, 0);
    check({run, "_wraddr"}, if_a.dpath_result_wraddr, 0);
`ifdef CONV_CTRL_PERF_CNT_EN
    check({run, "_perf"}, perf_a, 0);
`endif
  endtask

  initial begin
    reset = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    if_a.last_val = 1'b0;
    if_b.last_val = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_a("reset");
    check("reset_b_busy", busy_b, 0);
    reset = 1'b0;
    @(negedge clk);

    run_layer();
    check_layer("run1");

    start_a = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      start_a = 1'b0;
    end
    check("midrun_busy", busy_a, 1);
    check("midrun_rden", if_a.img_rden, 1);
    reset = 1'b1;
    @(negedge clk);
    check_idle_a("abort");
    reset = 1'b0;
    @(negedge clk);
    check("abort_no_done", done_a, 0);

    run_layer();
    check_layer("run2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/conv_bram_sr_fast_ctrl.md
Name: conv_bram_sr_fast_ctrl

Overview:
Control stage directly upstream of the fast shift-register convolution datapath.
- Walks the output feature map row by row.
- Issues per-bank read addresses to the image BRAMs. Image row r lives in bank r%FILTER_L at address (r/FILTER_L)*IMG_W + w.
- Drives the datapath controls dpath_wren, dpath_rotation_offset and dpath_result_wraddr, aligned to the BRAM read latency.
- Waits for the datapath's last_val, then reports done.

Parameters:
- IMG_W, 16, image width
- IMG_H, 16, image height
- FILTER_L, 3, square filter length, also the number of image BRAM banks
- STRIDE_W, 1, horizontal stride
- STRIDE_H, 1, vertical stride
- RD_LATENCY, 2, image BRAM read latency in cycles (>=1)
- RESULT_W, (IMG_W-FILTER_L)/STRIDE_W+1, derived
- RESULT_H, (IMG_H-FILTER_L)/STRIDE_H+1, derived
- BANK_ADDR_WIDTH, $clog2(((IMG_H+FILTER_L-1)/FILTER_L)*IMG_W), derived, per-bank address width
- FILTER_L_ADDR_WIDTH, $clog2(FILTER_L), derived
- RESULT_RAM_ADDR_WIDTH, $clog2(RESULT_W*RESULT_H), derived

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse that begins a layer; ignored unless the FSM is in IDLE
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse at layer completion
- img_rden  out  1  read enable to all image banks
- img_rdaddr  out  FILTER_L*BANK_ADDR_WIDTH  bank b address in slice [b*BANK_ADDR_WIDTH +: BANK_ADDR_WIDTH]
- dpath_wren  out  1  shift/valid into the datapath
- dpath_rotation_offset  out  FILTER_L_ADDR_WIDTH  top row of the window mod FILTER_L
- dpath_result_wraddr  out  RESULT_RAM_ADDR_WIDTH  result address tagged on this shift
- last_val  in  1  datapath's final-result-written flag

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset: FSM goes to IDLE. All outputs are 0 and all counters are cleared, including the delay pipeline contents. Reset in any state aborts immediately; no done pulse is produced.
- FSM states and transitions:
  - IDLE -> RUN on start.
  - RUN -> DRAIN after the issue cycle with oh=RESULT_H-1 and col=LAST_COL.
  - DRAIN -> DONE on last_val.
  - DONE -> IDLE unconditionally. done=1 only during the DONE cycle.
- Issue counters, all advancing in RUN:
  - col runs 0..LAST_COL, with LAST_COL=(RESULT_W-1)*STRIDE_W+FILTER_L-1.
  - oh runs 0..RESULT_H-1.
  - top=oh*STRIDE_H is held incrementally, with no multiplier.
  - ow is the next pending window index.
- RUN issues one column per cycle and never stalls:
  - img_rden=1.
  - Bank b address = (row_b/FILTER_L)*IMG_W + col, where row_b is the smallest row >= top with row_b%FILTER_L == b.
  - Each bank keeps its own row base (row_b/FILTER_L)*IMG_W. On a row advance the base moves by the stepped-over rows, computed with incremental compare-and-add only.
- Tagged controls (pre-delay values, issued in the same cycle as the column):
  - wren=1.
  - rotation_offset = top%FILTER_L, computed incrementally modulo FILTER_L.
  - wraddr = oh*RESULT_W + ow.
  - ow starts at 0 each row and increments after the column with col == ow*STRIDE_W+FILTER_L-1.
- Warm-up and stride-skipped columns carry the address of the upcoming window of the same row. The datapath pipeline is in-order, so the real write to that address overwrites those junk writes.
- All three tagged signals pass through a RD_LATENCY-deep register pipeline, so dpath_* lines up with img_data_in.
- Outside RUN, pre-delay wren=0 and img_rden=0. The DRAIN state therefore still shows the final RD_LATENCY delayed shifts.
- last_val outside DRAIN is ignored.
- Simultaneous reset and start: reset wins.
- Layer length: total issue cycles = RESULT_H*(LAST_COL+1).

Optional Feature:
- Macro: CONV_CTRL_PERF_CNT_EN.
- When defined, adds output perf_cycles [31:0]:
  - clears on the start that is accepted;
  - increments every cycle while busy;
  - holds its value after done;
  - saturates at 2^32-1;
  - reset value 0.
- When undefined, the port and the counter do not exist.

Decomposition:
- Shared package conv_ctrl_pkg:
  - FSM state enum (IDLE, RUN, DRAIN, DONE);
  - a function for the derived RESULT_W, RESULT_H and LAST_COL.
- One sub-module, conv_ctrl_delay_line: a parameterized WIDTH x DEPTH register pipeline with synchronous reset, used for the tagged signals.

Test Plan:
- Defaults, one start -> busy for RESULT_H*(LAST_COL+1)=14*16=224 issue cycles plus drain. First dpath_wren appears 2 cycles after the first img_rden. Exactly one done pulse, one cycle after last_val.
- Defaults, oh=1, col=5 -> img_rdaddr bank0=21, bank1=5, bank2=5; rotation_offset=1.
- Defaults, row 0 -> wraddr sequence 0,0,0,1,2,...,13; row 13 ends with wraddr 195.
- STRIDE_W=2, STRIDE_H=2 -> RESULT 7x7, LAST_COL=14, rows top=0,2,...,12. Row 0 wraddr sequence 0,0,0,1,1,2,2,...,6,6.
- Reset asserted mid-RUN -> next cycle all outputs are 0 and the FSM is in IDLE. A following start runs a complete layer correctly. start pulsed while busy has no effect.
- With CONV_CTRL_PERF_CNT_EN, defaults -> perf_cycles equals the busy cycle count. A second start clears it and it recounts to the same value.
